// File: rtl/lvt_memory_if.sv
// Per-port address, write-enable, write-data and read-data bundle for lvt_memory.
// The master drives accesses and the slave (the memory) returns registered read data.
interface lvt_memory_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 512,
  parameter int PORTS = 8
);
  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0]    addr [PORTS];
  logic             en   [PORTS];
  logic [WIDTH-1:0] d    [PORTS];
  logic [WIDTH-1:0] q    [PORTS];

  modport master (output addr, output en, output d, input q);
  modport slave  (input addr, input en, input d, output q);
endinterface

// File: rtl/lvt_memory.sv
// Multi-ported RAM built from per-writer replicated banks plus a live value table
// that steers every read port to the bank set last written at its address.
module lvt_memory #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 512,
  parameter int PORTS = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  lvt_memory_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(PORTS);
  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] bank_r [PORTS][PORTS][DEPTH];
  logic [LW-1:0]    lvt_r  [DEPTH];
  logic [WIDTH-1:0] q_r    [PORTS];
  logic             win_s  [PORTS];
  logic             rd_ok_s[PORTS];

  // Range check each port and let the highest-index writer win any address conflict
  always_comb begin
    for (int w = 0; w < PORTS; w++) begin
      rd_ok_s[w] = ({1'b0, bus.addr[w]} < DEPTH_L);
      win_s[w]   = bus.en[w] && rd_ok_s[w];
      for (int v = w + 1; v < PORTS; v++) begin
        if (bus.en[v] && (bus.addr[v] == bus.addr[w])) begin
          win_s[w] = 1'b0;
        end else begin
          win_s[w] = win_s[w];
        end
      end
    end
  end

  // Bank storage: a winning writer updates every read-side copy of its own bank set
  always_ff @(posedge clk) begin
    for (int w = 0; w < PORTS; w++) begin
      if (rst_n && win_s[w]) begin
        for (int r = 0; r < PORTS; r++) begin
          bank_r[w][r][bus.addr[w]] <= bus.d[w];
        end
      end
    end
  end

  // Live value table: remembers which write port holds the current value of each word
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        lvt_r[i] <= '0;
      end
    end else begin
      for (int w = 0; w < PORTS; w++) begin
        if (win_s[w]) begin
          lvt_r[bus.addr[w]] <= LW'(w);
        end
      end
    end
  end

  // Registered read mux; nonblocking update gives read-first behaviour
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < PORTS; r++) begin
        q_r[r] <= '0;
      end
    end else begin
      for (int r = 0; r < PORTS; r++) begin
        if (rd_ok_s[r]) begin
          q_r[r] <= bank_r[lvt_r[bus.addr[r]]][r][bus.addr[r]];
        end else begin
          q_r[r] <= '0;
        end
      end
    end
  end

  for (genvar g = 0; g < PORTS; g++) begin : g_q
    assign bus.q[g] = q_r[g];
  end
endmodule

// File: tb/tb_lvt_memory.sv
// Directed, table-driven bench for lvt_memory with 8 ports, 512 x 32-bit words.
// Each table row is one clock cycle; checked ports compare q right after that edge.
module tb_lvt_memory;
  localparam int WIDTH = 32;
  localparam int DEPTH = 512;
  localparam int PORTS = 8;
  localparam int NV    = 16;

  typedef struct packed {
    logic [7:0]        en;
    logic [7:0][8:0]   addr;
    logic [7:0][31:0]  d;
    logic [7:0]        chk;
    logic [7:0][31:0]  exp;
  } vec_t;

  logic clk;
  logic rst_n;
  int   passed;
  int   total;
  vec_t tbl [NV];

  lvt_memory_if #(.WIDTH(WIDTH), .DEPTH(DEPTH), .PORTS(PORTS)) bus ();

  lvt_memory #(.WIDTH(WIDTH), .DEPTH(DEPTH), .PORTS(PORTS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_q(input string name, input int p, input logic [31:0] exp);
    total++;
    if (bus.q[p] !== exp) begin
      $display("FAIL %s port %0d: got %h expected %h", name, p, bus.q[p], exp);
    end else begin
      passed++;
    end
  endtask

  task automatic drive(input vec_t v);
    for (int p = 0; p < PORTS; p++) begin
      bus.en[p]   = v.en[p];
      bus.addr[p] = v.addr[p];
      bus.d[p]    = v.d[p];
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    @(negedge clk);
    drive(v);
    @(posedge clk);
    #1;
    for (int p = 0; p < PORTS; p++) begin
      if (v.chk[p]) check_q($sformatf("vec%0d", idx), p, v.exp[p]);
    end
  endtask

  task automatic idle_cycle();
    vec_t v;
    v = '0;
    run_vec(v, -1);
  endtask

  initial begin
    vec_t v;
    passed = 0;
    total  = 0;
    for (int i = 0; i < NV; i++) tbl[i] = '0;

    // basic cross-port
    tbl[0].en[0] = 1'b1; tbl[0].addr[0] = 9'd5; tbl[0].d[0] = 32'd42;
    tbl[2].addr[1] = 9'd5; tbl[2].chk[1] = 1'b1; tbl[2].exp[1] = 32'd42;
    tbl[3].addr[1] = 9'd5; tbl[3].chk[1] = 1'b1; tbl[3].exp[1] = 32'd42;
    // read-first across ports
    tbl[4].en[3] = 1'b1; tbl[4].addr[3] = 9'd10; tbl[4].d[3] = 32'h1111_1111;
    tbl[5].en[3] = 1'b1; tbl[5].addr[3] = 9'd10; tbl[5].d[3] = 32'hA5A5_A5A5;
    tbl[5].addr[4] = 9'd10; tbl[5].chk[4] = 1'b1; tbl[5].exp[4] = 32'h1111_1111;
    tbl[6].addr[4] = 9'd10; tbl[6].chk[4] = 1'b1; tbl[6].exp[4] = 32'hA5A5_A5A5;
    // LVT overwrite, port0 sees the old value during the second write
    tbl[7].en[2] = 1'b1; tbl[7].addr[2] = 9'd100; tbl[7].d[2] = 32'd7;
    tbl[8].en[6] = 1'b1; tbl[8].addr[6] = 9'd100; tbl[8].d[6] = 32'd9;
    tbl[8].addr[0] = 9'd100; tbl[8].chk[0] = 1'b1; tbl[8].exp[0] = 32'd7;
    for (int p = 0; p < PORTS; p++) begin
      tbl[9].addr[p] = 9'd100; tbl[9].chk[p] = 1'b1; tbl[9].exp[p] = 32'd9;
    end
    // write conflict: port5 must win
    tbl[10].en[1] = 1'b1; tbl[10].addr[1] = 9'd3; tbl[10].d[1] = 32'd11;
    tbl[10].en[5] = 1'b1; tbl[10].addr[5] = 9'd3; tbl[10].d[5] = 32'd55;
    for (int p = 0; p < PORTS; p++) begin
      tbl[11].addr[p] = 9'd3; tbl[11].chk[p] = 1'b1; tbl[11].exp[p] = 32'd55;
    end
    // full parallel write then rotated read
    for (int p = 0; p < PORTS; p++) begin
      tbl[12].en[p]   = 1'b1;
      tbl[12].addr[p] = 9'(p);
      tbl[12].d[p]    = 32'((p + 1) * 1000);
      tbl[13].addr[p] = 9'((p + 1) % 8);
      tbl[13].chk[p]  = 1'b1;
      tbl[13].exp[p]  = 32'((((p + 1) % 8) + 1) * 1000);
    end
    // same-port read-during-write returns old data
    tbl[14].en[2] = 1'b1; tbl[14].addr[2] = 9'd2; tbl[14].d[2] = 32'hDEAD_0002;
    tbl[14].chk[2] = 1'b1; tbl[14].exp[2] = 32'd3000;
    tbl[15].addr[2] = 9'd2; tbl[15].chk[2] = 1'b1; tbl[15].exp[2] = 32'hDEAD_0002;
    tbl[15].addr[7] = 9'd2; tbl[15].chk[7] = 1'b1; tbl[15].exp[7] = 32'hDEAD_0002;

    drive('0);
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    for (int p = 0; p < PORTS; p++) check_q("reset_q", p, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) run_vec(tbl[i], i);

    // addr 20: port0 then port4 write; after reset the LVT points back to bank set 0
    v = '0; v.en[0] = 1'b1; v.addr[0] = 9'd20; v.d[0] = 32'h0000_0020;
    run_vec(v, 100);
    v = '0; v.en[4] = 1'b1; v.addr[4] = 9'd20; v.d[4] = 32'h0000_0044;
    run_vec(v, 101);
    v = '0; v.addr[6] = 9'd20; v.chk[6] = 1'b1; v.exp[6] = 32'h0000_0044;
    for (int p = 0; p < PORTS; p++) v.addr[p] = 9'd20;
    run_vec(v, 102);

    // asynchronous reset between edges, no clock needed for q to clear
    #2 rst_n = 1'b0;
    #1;
    for (int p = 0; p < PORTS; p++) check_q("async_reset_q", p, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    v = '0; v.addr[1] = 9'd20; v.chk[1] = 1'b1; v.exp[1] = 32'h0000_0020;
    run_vec(v, 103);
    v = '0; v.en[0] = 1'b1; v.addr[0] = 9'd5; v.d[0] = 32'd77;
    run_vec(v, 104);
    idle_cycle();
    v = '0; v.addr[1] = 9'd5; v.chk[1] = 1'b1; v.exp[1] = 32'd77;
    run_vec(v, 105);
    run_vec(v, 106);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
